zorgian_coin_dispenser: RTL and testbench

ZORGIAN_COIN_DISPENSER -- requirements
Module: zorgian_coin_dispenser

---
 rtl/zorgian_coin_dispenser.sv | 187 ++++++++++++++++++
 tb/tb_zorgian_coin_dispenser.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zorgian_coin_dispenser.sv
// rtl/zorgian_coin_dispenser.sv - two-coin dispense sequencer with stock tracking
//
// Ports:
//   clock, reset                     single clock, synchronous active-high reset
//   go                               start one dispense transaction (IDLE only)
//   FirstCoin, SecondCoin, Remaining change-box result, latched at accepted go
//   ExactAmount, CoughUpMore         change-box status; either one skips ejection
//   NotEnoughChange                  change-box status; visible only through owed
//   restock, restock_P/T/C           load stock counters (IDLE only, beats go)
//   eject_ready                      coin mechanism accepts the presented coin
//   eject_valid, eject_coin          coin presented to the mechanism
//   Pentagons, Triangles, Circles    current stock counters
//   busy, done                       transaction in progress / one-cycle completion
//   owed, dispensed                  Remaining at go / value ejected this transaction
//   stock_err                        sticky flag: a coin was ejected from empty stock

module zorgian_coin_dispenser (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] FirstCoin,
    input  logic [2:0] SecondCoin,
    input  logic [3:0] Remaining,
    input  logic       ExactAmount,
    input  logic       NotEnoughChange,
    input  logic       CoughUpMore,
    input  logic       restock,
    input  logic [1:0] restock_P,
    input  logic [1:0] restock_T,
    input  logic [1:0] restock_C,
    input  logic       eject_ready,
    output logic       eject_valid,
    output logic [2:0] eject_coin,
    output logic [1:0] Pentagons,
    output logic [1:0] Triangles,
    output logic [1:0] Circles,
    output logic       busy,
    output logic       done,
    output logic [3:0] owed,
    output logic [3:0] dispensed,
    output logic       stock_err
);

    localparam logic [2:0] COIN_NONE     = 3'b000;
    localparam logic [2:0] COIN_PENTAGON = 3'b101;
    localparam logic [2:0] COIN_TRIANGLE = 3'b011;
    localparam logic [2:0] COIN_CIRCLE   = 3'b001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EJECT1 = 2'd1,
        EJECT2 = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] first_q;
    logic [2:0] second_q;
    logic       accept_go;
    logic       transfer;
    logic [2:0] first_norm;

    // Shortage of change never changes sequencing; the caller sees it via owed.
    logic unused_status;
    assign unused_status = NotEnoughChange;

    // Unknown codes collapse to "none" so they can never reach the mechanism.
    function automatic logic [2:0] norm_coin(input logic [2:0] code);
        case (code)
            COIN_PENTAGON, COIN_TRIANGLE, COIN_CIRCLE: norm_coin = code;
            default:                                   norm_coin = COIN_NONE;
        endcase
    endfunction

    function automatic logic [3:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_PENTAGON: coin_value = 4'd5;
            COIN_TRIANGLE: coin_value = 4'd3;
            COIN_CIRCLE:   coin_value = 4'd1;
            default:       coin_value = 4'd0;
        endcase
    endfunction

    assign first_norm = norm_coin(FirstCoin);
    // restock has priority over go in IDLE.
    assign accept_go  = (state == IDLE) && go && !restock;
    assign transfer   = eject_valid && eject_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_go) begin
                    if ((first_norm != COIN_NONE) && !CoughUpMore && !ExactAmount) begin
                        state_next = EJECT1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            EJECT1: begin
                if (eject_ready) begin
                    state_next = (second_q != COIN_NONE) ? EJECT2 : DONE;
                end
            end
            EJECT2: begin
                if (eject_ready) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        eject_valid = 1'b0;
        eject_coin  = COIN_NONE;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            EJECT1: begin
                eject_valid = 1'b1;
                eject_coin  = first_q;
            end
            EJECT2: begin
                eject_valid = 1'b1;
                eject_coin  = second_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            first_q   <= COIN_NONE;
            second_q  <= COIN_NONE;
            owed      <= 4'd0;
            dispensed <= 4'd0;
            stock_err <= 1'b0;
            Pentagons <= 2'd0;
            Triangles <= 2'd0;
            Circles   <= 2'd0;
        end else begin
            if (accept_go) begin
                first_q   <= first_norm;
                second_q  <= norm_coin(SecondCoin);
                owed      <= Remaining;
                dispensed <= 4'd0;
            end
            if ((state == IDLE) && restock) begin
                Pentagons <= restock_P;
                Triangles <= restock_T;
                Circles   <= restock_C;
            end
            // An empty counter stays at zero; the coin still counts as dispensed.
            if (transfer) begin
                dispensed <= dispensed + coin_value(eject_coin);
                case (eject_coin)
                    COIN_PENTAGON: begin
                        if (Pentagons == 2'd0) stock_err <= 1'b1;
                        else                   Pentagons <= Pentagons - 2'd1;
                    end
                    COIN_TRIANGLE: begin
                        if (Triangles == 2'd0) stock_err <= 1'b1;
                        else                   Triangles <= Triangles - 2'd1;
                    end
                    COIN_CIRCLE: begin
                        if (Circles == 2'd0) stock_err <= 1'b1;
                        else                 Circles <= Circles - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zorgian_coin_dispenser.sv
// tb/tb_zorgian_coin_dispenser.sv - self-checking bench for zorgian_coin_dispenser

module tb_zorgian_coin_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic [2:0] FirstCoin;
    logic [2:0] SecondCoin;
    logic [3:0] Remaining;
    logic       ExactAmount;
    logic       NotEnoughChange;
    logic       CoughUpMore;
    logic       restock;
    logic [1:0] restock_P;
    logic [1:0] restock_T;
    logic [1:0] restock_C;
    logic       eject_ready;
    logic       eject_valid;
    logic [2:0] eject_coin;
    logic [1:0] Pentagons;
    logic [1:0] Triangles;
    logic [1:0] Circles;
    logic       busy;
    logic       done;
    logic [3:0] owed;
    logic [3:0] dispensed;
    logic       stock_err;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    logic [2:0] vtrace[$];
    int         mP, mT, mC;
    logic       mErr;
    logic [3:0] exp_disp;
    logic [3:0] exp_owed;

    zorgian_coin_dispenser dut (
        .clock(clock), .reset(reset), .go(go),
        .FirstCoin(FirstCoin), .SecondCoin(SecondCoin), .Remaining(Remaining),
        .ExactAmount(ExactAmount), .NotEnoughChange(NotEnoughChange),
        .CoughUpMore(CoughUpMore), .restock(restock),
        .restock_P(restock_P), .restock_T(restock_T), .restock_C(restock_C),
        .eject_ready(eject_ready), .eject_valid(eject_valid), .eject_coin(eject_coin),
        .Pentagons(Pentagons), .Triangles(Triangles), .Circles(Circles),
        .busy(busy), .done(done), .owed(owed), .dispensed(dispensed),
        .stock_err(stock_err)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] model_norm(input logic [2:0] c);
        if (c == 3'b101 || c == 3'b011 || c == 3'b001) return c;
        return 3'b000;
    endfunction

    function automatic logic [3:0] model_value(input logic [2:0] c);
        case (c)
            3'b101:  return 4'd5;
            3'b011:  return 4'd3;
            3'b001:  return 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    task automatic model_eject(input logic [2:0] c);
        exp_q.push_back(c);
        exp_disp = exp_disp + model_value(c);
        case (c)
            3'b101: if (mP == 0) mErr = 1'b1; else mP--;
            3'b011: if (mT == 0) mErr = 1'b1; else mT--;
            default: if (mC == 0) mErr = 1'b1; else mC--;
        endcase
    endtask

    task automatic do_restock(input int p, input int t, input int c);
        restock   = 1'b1;
        restock_P = 2'(p);
        restock_T = 2'(t);
        restock_C = 2'(c);
        @(negedge clock);
        restock = 1'b0;
        mP = p; mT = t; mC = c;
    endtask

    // Drives go for one edge, pushes the expected coins, then scrambles the
    // change-box inputs to show they are not re-sampled mid-transaction.
    task automatic do_go(input logic [2:0] f, input logic [2:0] s, input logic [3:0] rem,
                         input logic cum, input logic ex, input logic nec);
        logic [2:0] nf, ns;
        FirstCoin = f; SecondCoin = s; Remaining = rem;
        CoughUpMore = cum; ExactAmount = ex; NotEnoughChange = nec;
        go = 1'b1;
        nf = model_norm(f);
        ns = model_norm(s);
        exp_disp = 4'd0;
        exp_owed = rem;
        exp_q.delete();
        obs_q.delete();
        vtrace.delete();
        if (nf != 3'b000 && !cum && !ex) begin
            model_eject(nf);
            if (ns != 3'b000) model_eject(ns);
        end
        @(negedge clock);
        go = 1'b0;
        FirstCoin = 3'b001; SecondCoin = 3'b001; Remaining = 4'hF;
        CoughUpMore = 1'b0; ExactAmount = 1'b0; NotEnoughChange = 1'b0;
    endtask

    // Runs until done is seen; holds eject_ready low for the first `hold`
    // offered cycles. Records accepted coins and every presented coin.
    task automatic run_txn(input int hold, output int cycles, output bit timed_out);
        int waited = 0;
        cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (eject_valid) begin
                vtrace.push_back(eject_coin);
                if (waited < hold) begin
                    eject_ready = 1'b0;
                    waited++;
                end else begin
                    eject_ready = 1'b1;
                    obs_q.push_back(eject_coin);
                end
            end else begin
                eject_ready = 1'b0;
            end
            @(negedge clock);
            cycles++;
        end
        eject_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++;
        if ({eject_valid, eject_coin, busy, done, owed, dispensed, stock_err,
             Pentagons, Triangles, Circles} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ev=%b coin=%b busy=%b done=%b owed=%0d disp=%0d err=%b P=%0d T=%0d C=%0d, want all zero",
                     eject_valid, eject_coin, busy, done, owed, dispensed, stock_err, Pentagons, Triangles, Circles);
        end
        reset = 1'b0;
        @(negedge clock);
        mP = 0; mT = 0; mC = 0; mErr = 1'b0;
    endtask

    task automatic test_basic;
        int cyc; bit to;
        do_restock(3, 3, 3);
        checks++;
        if ({Pentagons, Triangles, Circles} !== 6'b11_11_11) begin
            errors++;
            $display("FAIL restock_load: got P=%0d T=%0d C=%0d, want 3 3 3", Pentagons, Triangles, Circles);
        end
        do_go(3'b101, 3'b011, 4'd0, 1'b0, 1'b0, 1'b0);
        run_txn(0, cyc, to);
        checks++;
        if (to || cyc != 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles timeout=%0b, want 2", cyc, to);
        end
        while (exp_q.size() > 0) begin
            logic [2:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL basic_coin: got %b, want %b", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra: got %0d extra coins, want 0", obs_q.size()); end
        checks++;
        if (Pentagons !== 2'(mP) || Triangles !== 2'(mT) || Circles !== 2'(mC) ||
            dispensed !== exp_disp || owed !== exp_owed || stock_err !== mErr) begin
            errors++;
            $display("FAIL basic_state: got P=%0d T=%0d C=%0d disp=%0d owed=%0d err=%b, want %0d %0d %0d %0d %0d %b",
                     Pentagons, Triangles, Circles, dispensed, owed, stock_err, mP, mT, mC, exp_disp, exp_owed, mErr);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b after done cycle, want 0 0", done, busy);
        end
    endtask

    task automatic test_hold;
        int cyc; bit to;
        do_restock(1, 3, 3);
        do_go(3'b101, 3'b011, 4'd2, 1'b0, 1'b0, 1'b1);
        run_txn(3, cyc, to);
        checks++;
        if (to || cyc != 5) begin
            errors++;
            $display("FAIL hold_latency: got %0d cycles timeout=%0b, want 5", cyc, to);
        end
        checks++;
        if (vtrace.size() != 5) begin
            errors++;
            $display("FAIL hold_trace_len: got %0d presented cycles, want 5", vtrace.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (vtrace[i] !== ((i < 4) ? 3'b101 : 3'b011)) begin
                    errors++;
                    $display("FAIL hold_stable[%0d]: got %b, want %b", i, vtrace[i], (i < 4) ? 3'b101 : 3'b011);
                end
            end
        end
        while (exp_q.size() > 0) begin
            logic [2:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL hold_coin: got %b, want %b", o, e); end
        end
        checks++;
        if (owed !== 4'd2 || dispensed !== 4'd8 || Pentagons !== 2'(mP) || Triangles !== 2'(mT) || stock_err !== mErr) begin
            errors++;
            $display("FAIL hold_state: got owed=%0d disp=%0d P=%0d T=%0d err=%b, want 2 8 %0d %0d %b",
                     owed, dispensed, Pentagons, Triangles, stock_err, mP, mT, mErr);
        end
        @(negedge clock);
    endtask

    task automatic test_no_eject;
        int cyc; bit to;
        for (int k = 0; k < 2; k++) begin
            do_go(3'b101, 3'b011, 4'd7, k == 0, k == 1, 1'b0);
            checks++;
            if (done !== 1'b1 || eject_valid !== 1'b0) begin
                errors++;
                $display("FAIL no_eject_latency[%0d]: got done=%b ev=%b at N+1, want 1 0", k, done, eject_valid);
            end
            run_txn(0, cyc, to);
            checks++;
            if (to || obs_q.size() != 0 || exp_q.size() != 0 || dispensed !== 4'd0 || owed !== 4'd7 ||
                Pentagons !== 2'(mP) || Triangles !== 2'(mT) || Circles !== 2'(mC)) begin
                errors++;
                $display("FAIL no_eject_state[%0d]: got coins=%0d disp=%0d owed=%0d P=%0d T=%0d C=%0d, want 0 0 7 %0d %0d %0d",
                         k, obs_q.size(), dispensed, owed, Pentagons, Triangles, Circles, mP, mT, mC);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_invalid_codes;
        int cyc; bit to;
        do_restock(2, 2, 2);
        do_go(3'b111, 3'b011, 4'd1, 1'b0, 1'b0, 1'b0);
        run_txn(0, cyc, to);
        checks++;
        if (to || cyc != 0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL invalid_first: got cycles=%0d coins=%0d, want 0 0", cyc, obs_q.size());
        end
        @(negedge clock);
        do_go(3'b011, 3'b110, 4'd0, 1'b0, 1'b0, 1'b0);
        run_txn(0, cyc, to);
        checks++;
        if (to || cyc != 1 || obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0] ||
            dispensed !== exp_disp || Triangles !== 2'(mT)) begin
            errors++;
            $display("FAIL invalid_second: got cycles=%0d coins=%0d disp=%0d T=%0d, want 1 1 %0d %0d",
                     cyc, obs_q.size(), dispensed, Triangles, exp_disp, mT);
        end
        @(negedge clock);
    endtask

    task automatic test_underflow;
        int cyc; bit to;
        do_restock(2, 2, 0);
        do_go(3'b001, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        run_txn(0, cyc, to);
        checks++;
        if (to || obs_q.size() != 1 || obs_q[0] !== 3'b001 || Circles !== 2'd0 ||
            stock_err !== 1'b1 || dispensed !== 4'd1) begin
            errors++;
            $display("FAIL underflow: got coins=%0d C=%0d err=%b disp=%0d, want 1 0 1 1",
                     obs_q.size(), Circles, stock_err, dispensed);
        end
        @(negedge clock);
        do_go(3'b101, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        run_txn(0, cyc, to);
        checks++;
        if (to || stock_err !== 1'b1 || Pentagons !== 2'(mP) || dispensed !== 4'd5) begin
            errors++;
            $display("FAIL err_sticky: got err=%b P=%0d disp=%0d, want 1 %0d 5", stock_err, Pentagons, dispensed, mP);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int cyc; bit to;
        do_restock(3, 3, 3);
        for (int k = 0; k < 2; k++) begin
            do_go(k == 0 ? 3'b101 : 3'b011, k == 0 ? 3'b001 : 3'b001, 4'(k + 3), 1'b0, 1'b0, 1'b0);
            run_txn(0, cyc, to);
            while (exp_q.size() > 0) begin
                logic [2:0] e, o;
                e = exp_q.pop_front();
                o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
                checks++;
                if (o !== e) begin errors++; $display("FAIL b2b_coin[%0d]: got %b, want %b", k, o, e); end
            end
            checks++;
            if (to || dispensed !== exp_disp || owed !== exp_owed ||
                Pentagons !== 2'(mP) || Triangles !== 2'(mT) || Circles !== 2'(mC)) begin
                errors++;
                $display("FAIL b2b_state[%0d]: got disp=%0d owed=%0d P=%0d T=%0d C=%0d, want %0d %0d %0d %0d %0d",
                         k, dispensed, owed, Pentagons, Triangles, Circles, exp_disp, exp_owed, mP, mT, mC);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc; bit to;
        do_restock(3, 3, 3);
        do_go(3'b101, 3'b011, 4'd4, 1'b0, 1'b0, 1'b0);
        go = 1'b1; restock = 1'b1;
        restock_P = 2'd0; restock_T = 2'd0; restock_C = 2'd0;
        FirstCoin = 3'b001; SecondCoin = 3'b001; Remaining = 4'd9;
        eject_ready = 1'b0;
        @(negedge clock);
        go = 1'b0; restock = 1'b0;
        checks++;
        if (busy !== 1'b1 || eject_coin !== 3'b101 || Pentagons !== 2'd3 || owed !== 4'd4) begin
            errors++;
            $display("FAIL busy_ignore_mid: got busy=%b coin=%b P=%0d owed=%0d, want 1 101 3 4",
                     busy, eject_coin, Pentagons, owed);
        end
        run_txn(0, cyc, to);
        while (exp_q.size() > 0) begin
            logic [2:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'bxxx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL busy_ignore_coin: got %b, want %b", o, e); end
        end
        checks++;
        if (to || owed !== 4'd4 || Pentagons !== 2'(mP) || Triangles !== 2'(mT) || Circles !== 2'(mC)) begin
            errors++;
            $display("FAIL busy_ignore_end: got owed=%0d P=%0d T=%0d C=%0d, want 4 %0d %0d %0d",
                     owed, Pentagons, Triangles, Circles, mP, mT, mC);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        do_restock(3, 3, 3);
        do_go(3'b101, 3'b011, 4'd6, 1'b0, 1'b0, 1'b0);
        eject_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (eject_valid !== 1'b1 || eject_coin !== 3'b011) begin
            errors++;
            $display("FAIL reset_mid_setup: got ev=%b coin=%b, want 1 011", eject_valid, eject_coin);
        end
        eject_ready = 1'b0;
        reset = 1'b1;
        go = 1'b1; restock = 1'b1;
        @(negedge clock);
        reset = 1'b0; go = 1'b0; restock = 1'b0;
        mP = 0; mT = 0; mC = 0; mErr = 1'b0;
        exp_q.delete();
        checks++;
        if ({eject_valid, eject_coin, busy, done, owed, dispensed, stock_err,
             Pentagons, Triangles, Circles} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid: got ev=%b coin=%b busy=%b done=%b owed=%0d disp=%0d err=%b P=%0d T=%0d C=%0d, want all zero",
                     eject_valid, eject_coin, busy, done, owed, dispensed, stock_err, Pentagons, Triangles, Circles);
        end
        FirstCoin = 3'b101; SecondCoin = 3'b011;
        go = 1'b1; restock = 1'b1;
        restock_P = 2'd1; restock_T = 2'd2; restock_C = 2'd3;
        @(negedge clock);
        go = 1'b0; restock = 1'b0;
        mP = 1; mT = 2; mC = 3;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Pentagons !== 2'd1 || Triangles !== 2'd2 || Circles !== 2'd3) begin
            errors++;
            $display("FAIL go_restock: got busy=%b done=%b P=%0d T=%0d C=%0d, want 0 0 1 2 3",
                     busy, done, Pentagons, Triangles, Circles);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || eject_valid !== 1'b0) begin
            errors++;
            $display("FAIL go_restock_after: got busy=%b ev=%b, want 0 0", busy, eject_valid);
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; restock = 1'b0; eject_ready = 1'b0;
        FirstCoin = 3'b000; SecondCoin = 3'b000; Remaining = 4'd0;
        ExactAmount = 1'b0; NotEnoughChange = 1'b0; CoughUpMore = 1'b0;
        restock_P = 2'd0; restock_T = 2'd0; restock_C = 2'd0;
        mP = 0; mT = 0; mC = 0; mErr = 1'b0;
        exp_disp = 4'd0; exp_owed = 4'd0;
        @(negedge clock);
        test_reset;
        test_basic;
        test_hold;
        test_no_eject;
        test_invalid_codes;
        test_underflow;
        test_back_to_back;
        test_busy_ignore;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
